edge_det_filt: RTL and testbench

EDGE_DET_FILT -- requirements
Module: edge_det_filt

---
 rtl/edge_det_filt_pkg.sv | 30 +++
 rtl/edge_det_filt_if.sv | 24 ++
 rtl/edge_filt_chan.sv | 74 +++++++
 rtl/sync.sv | 28 ++
 rtl/edge_det_filt.sv | 78 +++++++
 tb/tb_edge_det_filt.sv | 246 ++++++++++++++++++++++++
 6 files changed

// File: rtl/edge_det_filt_pkg.sv
// Shared types for the edge detector / debounce filter: edge-select
// encodings, arm state machine states and the edge-select helper.
package edge_det_filt_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        RISE = 2'b01,
        FALL = 2'b10,
        BOTH = 2'b11
    } edge_mode_e;

    typedef enum logic {
        WAIT = 1'b0,
        RUN  = 1'b1
    } arm_state_e;

    // Number of clock edges spent in WAIT after reset is released.
    localparam int ARM_EDGES = 2;

    // True when a level change in the given direction is enabled by modeSel.
    function automatic logic edgeSelected(input logic [1:0] modeSel, input logic rising);
        edge_mode_e m;
        m = edge_mode_e'(modeSel);
        if (rising) begin
            return (m == RISE) || (m == BOTH);
        end
        return (m == FALL) || (m == BOTH);
    endfunction

endpackage

// File: rtl/edge_det_filt_if.sv
// Channel bus of the edge detector: raw inputs and controls in, filtered
// level, event pulses, sticky flags and interrupt out.
interface edge_det_filt_if #(
    parameter int DATAWIDTH = 1
);
    logic [DATAWIDTH-1:0]   i;
    logic [2*DATAWIDTH-1:0] mode;
    logic [DATAWIDTH-1:0]   clr;
    logic [DATAWIDTH-1:0]   mask;
    logic [DATAWIDTH-1:0]   level;
    logic [DATAWIDTH-1:0]   o;
    logic [DATAWIDTH-1:0]   sticky;
    logic                   irq;

    modport master (
        output i, mode, clr, mask,
        input  level, o, sticky, irq
    );

    modport slave (
        input  i, mode, clr, mask,
        output level, o, sticky, irq
    );
endinterface

// File: rtl/edge_filt_chan.sv
// One channel: persistence filter, debounced level, edge pulse and sticky flag.
module edge_filt_chan
    import edge_det_filt_pkg::*;
#(
    parameter int FILT = 4
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       run_i,
    input  logic       armLoad_i,
    input  logic       synced_i,
    input  logic       syncNext_i,
    input  logic [1:0] mode_i,
    input  logic       clr_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic       sticky_o
);
    localparam int CW = $clog2(FILT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pend_q, pend_d;
    logic          o_q, o_d;
    logic          sticky_q, sticky_d;

    // Next-state: count persistence of a synced/level mismatch, accept the
    // change on the FILT-th cycle and queue a pulse if that direction is enabled.
    // At the arming edge level takes the value the synchronizer output assumes
    // at this same edge, so level and synced agree with no spurious event.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        pend_d   = 1'b0;
        if (armLoad_i) begin
            cnt_d   = '0;
            level_d = syncNext_i;
        end else if (!run_i) begin
            cnt_d = '0;
        end else if (synced_i == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = synced_i;
            pend_d  = edgeSelected(mode_i, synced_i);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        o_d      = pend_q;
        sticky_d = o_q | (sticky_q & ~clr_i);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q    <= '0;
            level_q  <= 1'b0;
            pend_q   <= 1'b0;
            o_q      <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            pend_q   <= pend_d;
            o_q      <= o_d;
            sticky_q <= sticky_d;
        end
    end

    assign level_o  = level_q;
    assign pulse_o  = o_q;
    assign sticky_o = sticky_q;
endmodule

// File: rtl/sync.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
// meta_o is the first stage, exposed only for the arming load.
module sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] meta_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // Shift the raw inputs through two flops to resolve metastability.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign meta_o = stage1_q;
    assign q_o    = stage2_q;
endmodule

// File: rtl/edge_det_filt.sv
// Multi-channel synchronizing edge detector with debounce filter, sticky
// event flags and a masked interrupt. An arm state machine keeps all
// channels quiet for the first edges after reset.
module edge_det_filt
    import edge_det_filt_pkg::*;
#(
    parameter int DATAWIDTH = 1,
    parameter int FILT      = 4
) (
    input  logic           clk,
    input  logic           reset_l,
    edge_det_filt_if.slave bus
);
    localparam int ACW = $clog2(ARM_EDGES);
    localparam logic [ACW-1:0] ARM_LAST = ACW'(ARM_EDGES - 1);

    arm_state_e     state_q;
    logic [ACW-1:0] armCnt_q;
    logic           run;
    logic           armLoad;

    logic [DATAWIDTH-1:0] synced;
    logic [DATAWIDTH-1:0] syncNext;
    logic [DATAWIDTH-1:0] levelVec;
    logic [DATAWIDTH-1:0] oVec;
    logic [DATAWIDTH-1:0] stickyVec;

    // Arm FSM: stay in WAIT for ARM_EDGES edges after reset, then RUN for good.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= WAIT;
            armCnt_q <= '0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (armCnt_q == ARM_LAST) begin
                        state_q <= RUN;
                    end else begin
                        armCnt_q <= armCnt_q + 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign run     = (state_q == RUN);
    assign armLoad = (state_q == WAIT) && (armCnt_q == ARM_LAST);

    sync #(.WIDTH(DATAWIDTH)) uSync (
        .clk     (clk),
        .reset_l (reset_l),
        .d_i     (bus.i),
        .meta_o  (syncNext),
        .q_o     (synced)
    );

    for (genvar n = 0; n < DATAWIDTH; n++) begin : gChan
        edge_filt_chan #(.FILT(FILT)) uChan (
            .clk        (clk),
            .reset_l    (reset_l),
            .run_i      (run),
            .armLoad_i  (armLoad),
            .synced_i   (synced[n]),
            .syncNext_i (syncNext[n]),
            .mode_i     (bus.mode[2*n +: 2]),
            .clr_i      (bus.clr[n]),
            .level_o    (levelVec[n]),
            .pulse_o    (oVec[n]),
            .sticky_o   (stickyVec[n])
        );
    end

    assign bus.level  = levelVec;
    assign bus.o      = oVec;
    assign bus.sticky = stickyVec;
    assign bus.irq    = |(stickyVec & bus.mask);
endmodule

// File: tb/tb_edge_det_filt.sv
// Self-checking bench: two 4-channel instances (FILT=4 and FILT=1) share
// one stimulus stream; a window-based reference model predicts all outputs.
module tb_edge_det_filt;
    localparam int NCH    = 4;
    localparam int FILT_A = 4;
    localparam int FILT_B = 1;

    logic clk = 1'b0;
    logic reset_l;
    always #5 clk = ~clk;

    edge_det_filt_if #(.DATAWIDTH(NCH)) busA ();
    edge_det_filt_if #(.DATAWIDTH(NCH)) busB ();

    edge_det_filt #(.DATAWIDTH(NCH), .FILT(FILT_A)) dutA (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (busA.slave)
    );

    edge_det_filt #(.DATAWIDTH(NCH), .FILT(FILT_B)) dutB (
        .clk     (clk),
        .reset_l (reset_l),
        .bus     (busB.slave)
    );

    int checks;
    int errors;

    logic [NCH-1:0]   drvI;
    logic [2*NCH-1:0] drvMode;
    logic [NCH-1:0]   drvClr;
    logic [NCH-1:0]   drvMask;

    // Reference model: synced is the input delayed by two edges; a channel's
    // level flips once the last FILT synced samples taken while running all
    // differ from it; the pulse shows one cycle later, sticky one after that.
    logic [NCH-1:0] iHist[$];
    int             edgeCnt;
    logic [NCH-1:0] mLevel[2];
    logic [NCH-1:0] mPend[2];
    logic [NCH-1:0] mO[2];
    logic [NCH-1:0] mSticky[2];

    function automatic int filtOf(input int d);
        return (d == 0) ? FILT_A : FILT_B;
    endfunction

    always @(posedge clk or negedge reset_l) begin
        logic [NCH-1:0] newPend;
        logic           stable;
        int             f;
        if (!reset_l) begin
            iHist.delete();
            edgeCnt = 0;
            for (int d = 0; d < 2; d++) begin
                mLevel[d]  = '0;
                mPend[d]   = '0;
                mO[d]      = '0;
                mSticky[d] = '0;
            end
        end else begin
            edgeCnt++;
            iHist.push_back(drvI);
            for (int d = 0; d < 2; d++) begin
                f = filtOf(d);
                mSticky[d] = mO[d] | (mSticky[d] & ~drvClr);
                mO[d]      = mPend[d];
                newPend    = '0;
                if (edgeCnt == 2) begin
                    mLevel[d] = iHist[0];
                end else if (edgeCnt >= f + 2) begin
                    for (int c = 0; c < NCH; c++) begin
                        stable = 1'b1;
                        for (int x = edgeCnt - f + 1; x <= edgeCnt; x++) begin
                            if (iHist[x-3][c] == mLevel[d][c]) stable = 1'b0;
                        end
                        if (stable) begin
                            mLevel[d][c] = ~mLevel[d][c];
                            newPend[c]   = mLevel[d][c] ? drvMode[2*c] : drvMode[2*c+1];
                        end
                    end
                end
                mPend[d] = newPend;
            end
        end
    end

    task automatic applyStimulus(input logic [NCH-1:0] iv, input logic [2*NCH-1:0] mv,
                                 input logic [NCH-1:0] cv, input logic [NCH-1:0] kv);
        drvI = iv;  drvMode = mv;  drvClr = cv;  drvMask = kv;
        busA.i = iv; busA.mode = mv; busA.clr = cv; busA.mask = kv;
        busB.i = iv; busB.mode = mv; busB.clr = cv; busB.mask = kv;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("[TB] FAIL %s at %0t observed %0h expected %0h", tag, $time, obs, expd);
        end
    endtask

    task automatic checkOutput();
        checkVal("A.level",  busA.level,  mLevel[0]);
        checkVal("A.o",      busA.o,      mO[0]);
        checkVal("A.sticky", busA.sticky, mSticky[0]);
        checkVal("A.irq",    busA.irq,    |(mSticky[0] & drvMask));
        checkVal("B.level",  busB.level,  mLevel[1]);
        checkVal("B.o",      busB.o,      mO[1]);
        checkVal("B.sticky", busB.sticky, mSticky[1]);
        checkVal("B.irq",    busB.irq,    |(mSticky[1] & drvMask));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        logic [2*NCH-1:0] modes;
        logic [NCH-1:0]   rI, rClr, rMask;
        logic [2*NCH-1:0] rMode;
        int               pulses;
        checks  = 0;
        errors  = 0;
        reset_l = 1'b0;
        modes   = {NCH{2'b01}};
        applyStimulus('0, modes, '0, '0);
        repeat (3) tick();
        checkVal("rst.levelA",  busA.level,  0);
        checkVal("rst.oA",      busA.o,      0);
        checkVal("rst.stickyA", busA.sticky, 0);
        checkVal("rst.irqA",    busA.irq,    0);

        $display("[TB] release reset, arm, then rising edge on channel 0");
        reset_l = 1'b1;
        repeat (4) tick();
        applyStimulus(4'b0001, modes, '0, 4'b0001);
        for (int k = 1; k <= 9; k++) begin
            tick();
            checkVal("rise.levelA",  busA.level[0],  32'(k >= 6));
            checkVal("rise.oA",      busA.o[0],      32'(k == 7));
            checkVal("rise.stickyA", busA.sticky[0], 32'(k >= 8));
            checkVal("rise.levelB",  busB.level[0],  32'(k >= 3));
            checkVal("rise.oB",      busB.o[0],      32'(k == 4));
            checkVal("rise.stickyB", busB.sticky[0], 32'(k >= 5));
        end

        $display("[TB] clear collides with pulse on channel 1");
        applyStimulus(4'b0011, modes, '0, 4'b0010);
        repeat (7) tick();
        checkVal("clr.oA", busA.o[1], 1);
        applyStimulus(4'b0011, modes, 4'b0010, 4'b0010);
        tick();
        checkVal("clr.stickyHeld", busA.sticky[1], 1);
        checkVal("clr.irqHeld",    busA.irq,       1);
        tick();
        checkVal("clr.stickyGone", busA.sticky[1], 0);
        checkVal("clr.irqGone",    busA.irq,       0);
        applyStimulus(4'b0011, modes, '0, 4'b0010);

        $display("[TB] short glitch on channel 2");
        applyStimulus(4'b0111, modes, '0, 4'b0100);
        repeat (3) tick();
        applyStimulus(4'b0011, modes, '0, 4'b0100);
        for (int k = 0; k < 10; k++) begin
            tick();
            checkVal("glitch.levelA",  busA.level[2],  0);
            checkVal("glitch.oA",      busA.o[2],      0);
            checkVal("glitch.stickyA", busA.sticky[2], 0);
        end

        $display("[TB] fall-only then both-edge selection on channel 3");
        for (int pass = 0; pass < 2; pass++) begin
            modes  = (pass == 0) ? {2'b10, {3{2'b01}}} : {2'b11, {3{2'b01}}};
            pulses = 0;
            applyStimulus(4'b1011, modes, '0, '0);
            for (int k = 0; k < 10; k++) begin
                tick();
                if (busA.o[3]) pulses++;
            end
            applyStimulus(4'b0011, modes, '0, '0);
            for (int k = 0; k < 10; k++) begin
                tick();
                if (busA.o[3]) pulses++;
            end
            checkVal("select.pulses", pulses, (pass == 0) ? 1 : 2);
        end

        $display("[TB] reset in the middle of a filter run");
        applyStimulus(4'b0000, modes, '0, 4'b1111);
        repeat (3) tick();
        reset_l = 1'b0;
        repeat (2) tick();
        reset_l = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkVal("midrst.oA",     busA.o,     0);
            checkVal("midrst.levelA", busA.level, 0);
        end

        $display("[TB] input held high through reset");
        applyStimulus(4'b1111, modes, '0, 4'b1111);
        reset_l = 1'b0;
        repeat (3) tick();
        reset_l = 1'b1;
        tick();
        checkVal("hold.levelEarly", busA.level, 0);
        tick();
        checkVal("hold.levelA", busA.level, 4'hF);
        checkVal("hold.levelB", busB.level, 4'hF);
        for (int k = 0; k < 8; k++) begin
            tick();
            checkVal("hold.oA",      busA.o,      0);
            checkVal("hold.stickyA", busA.sticky, 0);
            checkVal("hold.irqA",    busA.irq,    0);
        end

        $display("[TB] randomized traffic");
        rI = 4'b1111; rMode = 8'hE4; rMask = 4'b1010;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(5) == 0) rI[c] = ~rI[c];
            end
            if ($urandom_range(19) == 0) rMode = 8'($urandom);
            if ($urandom_range(9) == 0)  rMask = 4'($urandom);
            rClr = '0;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(7) == 0) rClr[c] = 1'b1;
            end
            applyStimulus(rI, rMode, rClr, rMask);
            if ($urandom_range(149) == 0) begin
                reset_l = 1'b0;
                tick();
                tick();
                reset_l = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
